// File: rtl/cpu_pkg.sv
// cpu_pkg: shared program-counter width, address type and reset address
package cpu_pkg;
  localparam int PC_WIDTH = 8;
  typedef logic [PC_WIDTH-1:0] pc_t;
  localparam pc_t PC_RESET_VALUE = '0;
endpackage

// File: rtl/program_counter.sv
// program_counter: fetch-address register with increment, load and wrap pulse
module program_counter #(
  parameter int PC_WIDTH = cpu_pkg::PC_WIDTH,
  parameter logic [PC_WIDTH-1:0] RESET_VALUE = PC_WIDTH'(cpu_pkg::PC_RESET_VALUE),
  parameter int unsigned INC_STEP = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_increment,
  input  logic                load_en,
  input  logic [PC_WIDTH-1:0] load_value,
  output logic [PC_WIDTH-1:0] pc,
  output logic                wrap
);
  logic [PC_WIDTH:0]   sum;
  logic [PC_WIDTH-1:0] pc_next;
  logic                wrap_next;
  // One extra bit on the adder captures the carry that becomes wrap
  always_comb begin
    sum       = {1'b0, pc} + (PC_WIDTH+1)'(INC_STEP);
    pc_next   = load_en ? load_value : enable_increment ? sum[PC_WIDTH-1:0] : pc;
    wrap_next = !load_en && enable_increment && sum[PC_WIDTH];
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc   <= RESET_VALUE;
      wrap <= 1'b0;
    end else begin
      pc   <= pc_next;
      wrap <= wrap_next;
    end
  end
endmodule

// File: tb/tb_program_counter.sv
// tb_program_counter: model-checked directed test of default and 4-bit/step-3 counters
module tb_program_counter;
  logic       clk = 0;
  logic       reset_a = 0, en_a = 1, load_a = 0;
  logic [7:0] lv_a = 0, pc_a;
  logic       wrap_a;
  logic       reset_b = 0, en_b = 0, load_b = 0;
  logic [3:0] lv_b = 0, pc_b;
  logic       wrap_b;
  int         ma_pc = 0, mb_pc = 2;
  logic       ma_wrap = 0, mb_wrap = 0;
  int         checks = 0, errors = 0;

  always #5 clk = ~clk;

  program_counter dut_a (
    .clk(clk), .reset(reset_a), .enable_increment(en_a), .load_en(load_a),
    .load_value(lv_a), .pc(pc_a), .wrap(wrap_a)
  );

  program_counter #(.PC_WIDTH(4), .RESET_VALUE(4'h2), .INC_STEP(3)) dut_b (
    .clk(clk), .reset(reset_b), .enable_increment(en_b), .load_en(load_b),
    .load_value(lv_b), .pc(pc_b), .wrap(wrap_b)
  );

  // Reference behaviour: plain integer arithmetic, modulus taken explicitly
  always @(posedge clk or negedge reset_a)
    if (!reset_a) begin ma_pc <= 0; ma_wrap <= 0; end
    else if (load_a) begin ma_pc <= int'(lv_a); ma_wrap <= 0; end
    else if (en_a) begin ma_pc <= (ma_pc + 1) % 256; ma_wrap <= (ma_pc + 1) >= 256; end
    else ma_wrap <= 0;

  always @(posedge clk or negedge reset_b)
    if (!reset_b) begin mb_pc <= 2; mb_wrap <= 0; end
    else if (load_b) begin mb_pc <= int'(lv_b); mb_wrap <= 0; end
    else if (en_b) begin mb_pc <= (mb_pc + 3) % 16; mb_wrap <= (mb_pc + 3) >= 16; end
    else mb_wrap <= 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("model_pc_a", pc_a, ma_pc);
    chk("model_wrap_a", wrap_a, ma_wrap);
    chk("model_pc_b", pc_b, mb_pc);
    chk("model_wrap_b", wrap_b, mb_wrap);
  end

  initial begin
    int unsigned seq_b [5] = '{4'h5, 4'h8, 4'hB, 4'hE, 4'h1};
    repeat (10) @(negedge clk);
    chk("reset_pc", pc_a, 8'h00);
    chk("reset_wrap", wrap_a, 0);
    reset_a = 1;
    repeat (50) @(negedge clk);
    chk("count50", pc_a, 8'h32);
    en_a = 0;
    repeat (40) @(negedge clk);
    chk("hold40", pc_a, 8'h32);
    en_a = 1;
    repeat (30) @(negedge clk);
    chk("count30", pc_a, 8'h50);
    #2 reset_a = 0;
    #1 chk("async_reset_pc", pc_a, 8'h00);
    chk("async_reset_wrap", wrap_a, 0);
    @(negedge clk);
    reset_a = 1;
    repeat (30) @(negedge clk);
    chk("after_reset30", pc_a, 8'h1E);
    en_a = 0; load_a = 1; lv_a = 8'hFD;
    @(negedge clk);
    chk("load_fd", pc_a, 8'hFD);
    load_a = 0; en_a = 1;
    @(negedge clk); chk("wrap_fe", pc_a, 8'hFE); chk("wrap_fe_w", wrap_a, 0);
    @(negedge clk); chk("wrap_ff", pc_a, 8'hFF); chk("wrap_ff_w", wrap_a, 0);
    @(negedge clk); chk("wrap_00", pc_a, 8'h00); chk("wrap_00_w", wrap_a, 1);
    en_a = 0;
    @(negedge clk); chk("wrap_pulse_end", wrap_a, 0); chk("hold_00", pc_a, 8'h00);
    load_a = 1; lv_a = 8'h10;
    @(negedge clk); chk("load_10", pc_a, 8'h10);
    lv_a = 8'h40; en_a = 1;
    @(negedge clk); chk("load_priority", pc_a, 8'h40);
    load_a = 0;
    @(negedge clk); chk("inc_after_load", pc_a, 8'h41);
    load_a = 1; lv_a = 8'hFF; en_a = 0;
    @(negedge clk);
    lv_a = 8'h05; en_a = 1;
    @(negedge clk); chk("load_at_ff", pc_a, 8'h05); chk("load_no_wrap", wrap_a, 0);
    load_a = 0; en_a = 0;
    chk("b_reset_pc", pc_b, 4'h2);
    chk("b_reset_wrap", wrap_b, 0);
    reset_b = 1; en_b = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("b_step%0d", i), pc_b, seq_b[i]);
      chk($sformatf("b_wrap%0d", i), wrap_b, i == 4 ? 1 : 0);
    end
    en_b = 0;
    @(negedge clk); chk("b_hold", pc_b, 4'h1); chk("b_wrap_end", wrap_b, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Instruction-address register for the comp101 CPU core.
- Holds the current fetch address `pc`.
- Advances by one each enabled clock; otherwise holds its value.
- Supports a synchronous load for jump/branch targets and flags address wrap-around to the fetch/control logic.

Parameters:
- PC_WIDTH, 8, width of the program counter in bits.
- RESET_VALUE, 0, value loaded into pc while reset is asserted; must fit in PC_WIDTH bits.
- INC_STEP, 1, amount added to pc per enabled cycle; range 1..2**PC_WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable_increment  input  1  when 1, pc advances by INC_STEP on the next rising edge.
- load_en  input  1  when 1, pc takes load_value on the next rising edge.
- load_value  input  PC_WIDTH  jump/branch target address.
- pc  output  PC_WIDTH  current program counter; driven directly from the register, no combinational path from inputs.
- wrap  output  1  registered one-cycle pulse, high in the cycle after an increment overflowed past 2**PC_WIDTH-1.

Behaviour:
- Reset:
  - reset=0 immediately (asynchronously, no clock needed) forces pc=RESET_VALUE and wrap=0.
  - Both outputs hold those values for as long as reset=0.
  - Release (reset 0->1) is synchronised by the integrator. The first rising edge with reset=1 may update pc.
- Priority on each rising edge with reset=1:
  - load_en=1: pc <= load_value; wrap <= 0. enable_increment is ignored that cycle.
  - else enable_increment=1: pc <= (pc + INC_STEP) mod 2**PC_WIDTH; wrap <= 1 iff pc + INC_STEP >= 2**PC_WIDTH, else 0.
  - else: pc holds; wrap <= 0.
- Latency: one clock from a sampled enable/load to the visible pc change. pc is stable between rising edges.
- Arithmetic:
  - Unsigned, modulo 2**PC_WIDTH.
  - Carry-out is used only for wrap; no saturation.
  - Example (8-bit, step 1): 0xFF -> 0x00 with wrap=1 for one cycle.
- Enable held high for N edges advances pc by N*INC_STEP (mod 2**PC_WIDTH). With the 10 ns clock, 100 ns of enable gives +10.
- Reset mid-operation (enable or load active): reset wins immediately. No pending increment or load survives reset.
- Inputs must be stable around the rising edge. X on enable_increment/load_en while reset=1 is a bench error, not handled.

Decomposition:
- Shared package cpu_pkg:
  - PC_WIDTH constant.
  - typedef pc_t (logic [PC_WIDTH-1:0]).
  - PC_RESET_VALUE constant, consumed by fetch and branch units.
- Single flat module; no sub-module needed. Next-pc mux and adder live in one always_comb, register in one always_ff.

Test Plan:
- Reset: hold reset=0 for 100 ns with enable=1 -> pc=0x00, wrap=0 throughout; no counting during reset.
- Count/hold:
  - Release reset, enable=1 for 50 cycles -> pc=0x32.
  - Drop enable for 40 cycles -> pc stays 0x32.
  - Re-enable for 30 cycles -> pc=0x50.
- Async reset mid-run: at pc=0x50 with enable=1, assert reset=0 between clock edges -> pc=0x00 before the next edge; after release and 30 enabled cycles -> pc=0x1E.
- Wrap: load 0xFD, then enable for 3 cycles -> pc 0xFE, 0xFF, 0x00; wrap=1 only in the cycle pc=0x00.
- Load priority: pc=0x10, load_en=1, load_value=0x40, enable=1 for one edge -> pc=0x40 (not 0x11); next enabled edge -> 0x41.
- Parameter sweep: PC_WIDTH=4, INC_STEP=3, RESET_VALUE=2 -> reset gives 0x2; 5 enabled cycles give 2,5,8,B,E,1 with wrap pulse on reaching 1.
